// File: rtl/ram_ctrl.sv
// ram_ctrl: request-side sequencer for the single-port data RAM.
// Accepts single/burst read and write commands, drives the RAM one beat per
// cycle, auto-increments (and wraps) the address, and registers read data.
module ram_ctrl #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // command channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    // write data channel
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    // read data stream
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    // RAM side
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [LEN_W-1:0]    r_beat_cnt;
    logic                r_rd_valid;
    logic                r_rd_last;
    logic [DATA_W-1:0]   r_rd_data;

    logic                w_in_idle;
    logic                w_in_wr;
    logic                w_in_rd;
    logic                w_last_beat;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic [LEN_W-1:0]    w_cnt_dec;

    assign w_in_idle   = (r_state == S_IDLE);
    assign w_in_wr     = (r_state == S_WR);
    assign w_in_rd     = (r_state == S_RD);
    assign w_last_beat = (r_beat_cnt == '0);
    // Address arithmetic wraps silently modulo 2^ADDR_W.
    assign w_addr_inc  = r_cur_addr + ADDR_W'(1);
    assign w_cnt_dec   = r_beat_cnt - LEN_W'(1);

    // Command sequencing, beat counting and read-data capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cur_addr <= '0;
            r_beat_cnt <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            // Read strobes are single-cycle pulses unless re-armed in RD.
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_cur_addr <= req_addr;
                        r_beat_cnt <= req_len;
                        r_state    <= req_we ? S_WR : S_RD;
                    end
                end
                S_WR: begin
                    // The RAM commits the word on this same edge when wd_valid is high.
                    if (wd_valid) begin
                        r_cur_addr <= w_addr_inc;
                        r_beat_cnt <= w_cnt_dec;
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_RD: begin
                    // One beat per cycle, no back-pressure on the read stream.
                    r_rd_data  <= ram_q;
                    r_rd_valid <= 1'b1;
                    r_rd_last  <= w_last_beat;
                    r_cur_addr <= w_addr_inc;
                    r_beat_cnt <= w_cnt_dec;
                    if (w_last_beat) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake/status flags and RAM strobes decode directly from state.
    assign req_ready   = w_in_idle;
    assign wd_ready    = w_in_wr;
    assign busy        = !w_in_idle;
    assign ram_address = r_cur_addr;
    assign ram_data    = wd_data;
    assign ram_wren    = w_in_wr & wd_valid;
    assign ram_rden    = w_in_rd;

    assign rd_valid    = r_rd_valid;
    assign rd_last     = r_rd_last;
    assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: table-driven and randomized checks of ram_ctrl against a
// behavioural memory image, with a simple RAM model attached to the RAM port.
module tb_ram_ctrl;

    localparam int unsigned DATA_W = 14;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DEPTH  = 4096;

    typedef logic [15:0][DATA_W-1:0] beats_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        beats_t            d;    // write data, or expected read data
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_wren;
    logic              ram_rden;
    logic [DATA_W-1:0] ram_q;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference memory image: what the RAM must contain after each command.
    logic [DATA_W-1:0] model [DEPTH];

    // RAM model: synchronous write, combinational read.
    logic [DATA_W-1:0] ram [DEPTH];
    logic              ram_loaded = 1'b0;
    int                wren_cycles = 0;

    always #5 clk = ~clk;

    ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wd_valid    (wd_valid),
        .wd_ready    (wd_ready),
        .wd_data     (wd_data),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .busy        (busy),
        .ram_data    (ram_data),
        .ram_address (ram_address),
        .ram_wren    (ram_wren),
        .ram_rden    (ram_rden),
        .ram_q       (ram_q)
    );

    // RAM array: preloaded with a known pattern on the first edge.
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 14'(i * 7 + 3);
            ram_loaded <= 1'b1;
        end else if (ram_wren) begin
            ram[ram_address] <= ram_data;
            wren_cycles <= wren_cycles + 1;
        end
    end

    // Undriven read port modelled as zero rather than z.
    assign ram_q = ram_rden ? ram[ram_address] : '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // RAM strobes never overlap, and no read strobe while idle.
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1)
            check("strobe_excl", 32'({ram_wren & ram_rden, ram_rden & req_ready}), 32'd0);
    end

    function automatic beats_t model_seq(input logic [ADDR_W-1:0] addr, input int len);
        beats_t s = '0;
        for (int i = 0; i <= len; i++) s[i] = model[12'(addr + 12'(i))];
        return s;
    endfunction

    // Present a command at a negedge and return at the negedge after acceptance.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        int t = 0;
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("issue_timeout", 32'd0, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Write burst; 'stall' idle cycles inserted before every beat after the first.
    task automatic write_burst(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                               input beats_t d, input int stall);
        issue(1'b1, addr, len);
        #1;
        check("wr_wd_ready", 32'(wd_ready), 32'd1);
        check("wr_busy", 32'(busy), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            if (i > 0) begin
                for (int s = 0; s < stall; s++) begin
                    wd_valid = 1'b0;
                    #1;
                    check("wr_stall_wren", 32'(ram_wren), 32'd0);
                    check("wr_stall_addr", 32'(ram_address), 32'(12'(addr + 12'(i))));
                    @(negedge clk);
                end
            end
            wd_valid = 1'b1;
            wd_data  = d[i];
            #1;
            check("wr_wren", 32'(ram_wren), 32'd1);
            check("wr_addr", 32'(ram_address), 32'(12'(addr + 12'(i))));
            check("wr_data", 32'(ram_data), 32'(d[i]));
            @(negedge clk);
            model[12'(addr + 12'(i))] = d[i];
        end
        wd_valid = 1'b0;
        #1;
        check("wr_done_ready", 32'(req_ready), 32'd1);
        check("wr_done_busy", 32'(busy), 32'd0);
    endtask

    // Read burst compared beat-by-beat against expected data.
    task automatic read_burst(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                              input beats_t exp);
        issue(1'b0, addr, len);
        check("rd_lat_valid", 32'(rd_valid), 32'd0);
        check("rd_rden", 32'(ram_rden), 32'd1);
        check("rd_addr0", 32'(ram_address), 32'(addr));
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            check("rd_valid", 32'(rd_valid), 32'd1);
            check("rd_data", 32'(rd_data), 32'(exp[i]));
            check("rd_last", 32'(rd_last), 32'(i == int'(len)));
        end
        check("rd_end_ready", 32'(req_ready), 32'd1);
        check("rd_end_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rd_valid_drop", 32'(rd_valid), 32'd0);
        check("rd_last_drop", 32'(rd_last), 32'd0);
    endtask

    vec_t vecs [6];

    initial begin
        beats_t d;
        int     base;

        rst_n     = 1'b0;
        req_valid = 1'b1;  // reset must override a pending command
        req_we    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wd_valid  = 1'b1;
        wd_data   = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 14'(i * 7 + 3);

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_wd_ready", 32'(wd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_rden", 32'(ram_rden), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        req_valid = 1'b0;
        wd_valid  = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        // Directed vectors: single beat, 4-beat burst, wrap across 0xFFF.
        foreach (vecs[i]) vecs[i].d = '0;
        vecs[0].we = 1'b1; vecs[0].addr = 12'h020; vecs[0].len = 4'd0; vecs[0].d[0] = 14'h155;
        vecs[1].we = 1'b0; vecs[1].addr = 12'h020; vecs[1].len = 4'd0; vecs[1].d[0] = 14'h155;
        vecs[2].we = 1'b1; vecs[2].addr = 12'h010; vecs[2].len = 4'd3;
        vecs[2].d[0] = 14'h0A1; vecs[2].d[1] = 14'h0A2; vecs[2].d[2] = 14'h0A3; vecs[2].d[3] = 14'h0A4;
        vecs[3] = vecs[2]; vecs[3].we = 1'b0;
        vecs[4].we = 1'b1; vecs[4].addr = 12'hFFE; vecs[4].len = 4'd2;
        vecs[4].d[0] = 14'h3FFF; vecs[4].d[1] = 14'h0001; vecs[4].d[2] = 14'h2AAA;
        vecs[5] = vecs[4]; vecs[5].we = 1'b0;

        for (int i = 0; i < 6; i++) begin
            base = wren_cycles;
            if (vecs[i].we) begin
                write_burst(vecs[i].addr, vecs[i].len, vecs[i].d, 0);
                check("vec_wren_count", 32'(wren_cycles - base), 32'(int'(vecs[i].len) + 1));
            end else begin
                read_burst(vecs[i].addr, vecs[i].len, vecs[i].d);
                check("vec_rd_no_wren", 32'(wren_cycles - base), 32'd0);
            end
        end

        // Write with 2-cycle stalls between beats: exactly 3 RAM writes.
        d = '0; d[0] = 14'h1111; d[1] = 14'h2222; d[2] = 14'h3333;
        base = wren_cycles;
        write_burst(12'h200, 4'd2, d, 2);
        check("stall_wren_count", 32'(wren_cycles - base), 32'd3);
        read_burst(12'h200, 4'd2, model_seq(12'h200, 2));

        // Reset two beats into an 8-beat read.
        issue(1'b0, 12'h010, 4'd7);
        @(negedge clk);
        check("rrst_beat0", 32'(rd_valid), 32'd1);
        @(negedge clk);
        check("rrst_beat1", 32'(rd_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rrst_rd_valid", 32'(rd_valid), 32'd0);
        check("rrst_busy", 32'(busy), 32'd0);
        check("rrst_req_ready", 32'(req_ready), 32'd1);
        check("rrst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rrst_quiet", 32'(rd_valid), 32'd0);

        // Reset two beats into an 8-beat write; only those two words land.
        issue(1'b1, 12'h300, 4'd7);
        for (int i = 0; i < 2; i++) begin
            wd_valid = 1'b1;
            wd_data  = 14'(14'h2A00 + 14'(i));
            @(negedge clk);
            model[12'h300 + 12'(i)] = 14'(14'h2A00 + 14'(i));
        end
        wd_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("wrst_busy", 32'(busy), 32'd0);
        check("wrst_req_ready", 32'(req_ready), 32'd1);
        check("wrst_wd_ready", 32'(wd_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        read_burst(12'h300, 4'd7, model_seq(12'h300, 7));

        // Held command during an active burst is accepted only after the last beat.
        d = model_seq(12'h010, 3);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h010; req_len = 4'd3;
        @(negedge clk);
        req_addr = 12'hFFE; req_len = 4'd1;
        check("hs_not_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hs_rd_data", 32'(rd_data), 32'(d[i]));
            check("hs_rd_last", 32'(rd_last), 32'(i == 3));
            check("hs_ready", 32'(req_ready), 32'(i == 3));
            if (i < 3) check("hs_addr", 32'(ram_address), 32'(12'h010 + 12'(i + 1)));
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("hs_bubble_valid", 32'(rd_valid), 32'd0);
        check("hs_accept_busy", 32'(busy), 32'd1);
        check("hs_accept_addr", 32'(ram_address), 32'h0FFE);
        d = model_seq(12'hFFE, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hs2_valid", 32'(rd_valid), 32'd1);
            check("hs2_data", 32'(rd_data), 32'(d[i]));
            check("hs2_last", 32'(rd_last), 32'(i == 1));
        end
        @(negedge clk);
        check("hs2_drop", 32'(rd_valid), 32'd0);

        // Randomized commands in a window straddling the wrap point.
        for (int n = 0; n < 40; n++) begin
            logic [ADDR_W-1:0] a;
            logic [LEN_W-1:0]  l;
            a = 12'(12'hFF0 + 12'($urandom_range(0, 31)));
            l = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                d = '0;
                for (int i = 0; i < 16; i++) d[i] = 14'($urandom);
                write_burst(a, l, d, int'($urandom_range(0, 1)));
            end else begin
                read_burst(a, l, model_seq(a, int'(l)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
